// File: rtl/tagsort_pkg.sv
// Shared definitions for the tag-sorting linked-list controller.
// Contents:
//   NULL_PTR  - pointer value that terminates a list
//   NEXT_LSB  - bit offset of the next-pointer field inside a memory block
//   tag_lsb() - bit offset of the tag field; it sits directly above the pointer
//   state_t   - controller state encoding
package tagsort_pkg;

  localparam int NULL_PTR = 0;
  localparam int NEXT_LSB = 0;

  function automatic int tag_lsb(input int ptr_width);
    return ptr_width;
  endfunction

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_WALK   = 3'd2,
    S_LINK1  = 3'd3,
    S_LINK2  = 3'd4,
    S_POP_RD = 3'd5
  } state_t;

endpackage

// File: rtl/tagsort_list_ctrl.sv
// Sorted linked-list controller over an external dual-port memory.
// Tags are kept in one ascending singly linked list rooted at head. Unused
// blocks are chained in a free list rooted at free_head. Equal tags are
// inserted after the existing ones, so ties leave in arrival order.
//
// Ports:
//   clk, rst                  - clock (rising edge), async active-high reset
//   in_valid/in_ready/in_tag  - insert handshake
//   pop_req/pop_ready         - pop-minimum request / accept indication
//   out_valid/out_tag         - one-cycle pulse carrying the popped tag
//   count                     - number of stored tags
//   busy                      - high whenever the controller is not idle
//   r_addr1/r_data1           - read port 1 (list walk), 1-cycle latency
//   r_addr2/r_data2           - read port 2 (free list head), 1-cycle latency
//   wr_en/w_addr/w_data       - write port
//
// Block layout: next pointer in [N-1:0], tag in [N+TW-1:N], rest zero.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// INIT     | write block i with next = i+1 (wrapping), one block per cycle
// IDLE     | wait for pop or insert; reads head and free_head blocks
// WALK     | step along the list while the node tag is <= the new tag
// LINK1    | write the new node pointing at the first larger node
// LINK2    | splice the new node in after prev (or make it the new head)
// POP_RD   | return the head block to the free list, emit its tag
module tagsort_list_ctrl
  import tagsort_pkg::*;
#(
  parameter int N  = 13,
  parameter int B  = 64,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [TW-1:0] in_tag,
  input  logic          pop_req,
  output logic          pop_ready,
  output logic          out_valid,
  output logic [TW-1:0] out_tag,
  output logic [N-1:0]  count,
  output logic          busy,
  output logic [N-1:0]  r_addr1,
  output logic [N-1:0]  r_addr2,
  input  logic [B-1:0]  r_data1,
  input  logic [B-1:0]  r_data2,
  output logic          wr_en,
  output logic [N-1:0]  w_addr,
  output logic [B-1:0]  w_data
);

  localparam int            TAG_LSB  = tag_lsb(N);
  localparam logic [N-1:0]  NULL     = N'(NULL_PTR);
  localparam logic [N-1:0]  LAST_IDX = '1;   // also the full count

  state_t        state, state_nxt;
  logic [N-1:0]  init_idx;
  logic [N-1:0]  head, free_head, free_next;
  logic [N-1:0]  n_ptr, cur, prev;
  logic [TW-1:0] new_tag, prev_tag;
  logic          first_walk;

  logic          pop_go, ins_go, walk_adv;

  logic [N-1:0]  rd1_next, rd2_next;
  logic [TW-1:0] rd1_tag;

  assign rd1_next = r_data1[NEXT_LSB +: N];
  assign rd1_tag  = r_data1[TAG_LSB +: TW];
  assign rd2_next = r_data2[NEXT_LSB +: N];

  // Spare block bits carry nothing on read.
  logic unused_rd;
  assign unused_rd = ^{r_data1, r_data2};

  function automatic logic [B-1:0] mk_blk(input logic [TW-1:0] t, input logic [N-1:0] nx);
    logic [B-1:0] blk;
    blk = '0;
    blk[NEXT_LSB +: N] = nx;
    blk[TAG_LSB +: TW] = t;
    return blk;
  endfunction

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    pop_ready = 1'b0;
    pop_go    = 1'b0;
    ins_go    = 1'b0;
    walk_adv  = 1'b0;
    r_addr1   = '0;
    r_addr2   = '0;
    wr_en     = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    unique case (state)
      S_INIT: begin
        wr_en  = 1'b1;
        w_addr = init_idx;
        w_data = mk_blk('0, init_idx + 1'b1);
        if (init_idx == LAST_IDX) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        r_addr1   = head;
        r_addr2   = free_head;
        pop_ready = (count != '0);
        pop_go    = pop_req && pop_ready;
        // A pop in the same cycle wins; the insert is simply not taken yet.
        in_ready  = (count != LAST_IDX) && !pop_go;
        ins_go    = in_valid && in_ready;
        if (pop_go)      state_nxt = S_POP_RD;
        else if (ins_go) state_nxt = S_WALK;
      end
      S_WALK: begin
        r_addr2  = free_head;
        // <= keeps ties in arrival order: walk past every equal tag.
        walk_adv = (cur != NULL) && (rd1_tag <= new_tag);
        if (walk_adv) begin
          r_addr1 = rd1_next;
        end else begin
          r_addr1   = cur;
          state_nxt = S_LINK1;
        end
      end
      S_LINK1: begin
        wr_en     = 1'b1;
        w_addr    = n_ptr;
        w_data    = mk_blk(new_tag, cur);
        state_nxt = S_LINK2;
      end
      S_LINK2: begin
        if (prev != NULL) begin
          wr_en  = 1'b1;
          w_addr = prev;
          w_data = mk_blk(prev_tag, n_ptr);
        end
        state_nxt = S_IDLE;
      end
      S_POP_RD: begin
        wr_en     = 1'b1;
        w_addr    = head;
        w_data    = mk_blk('0, free_head);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
    // Keep the memory port quiet while reset is asserted.
    if (rst) begin
      wr_en  = 1'b0;
      w_addr = '0;
      w_data = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_idx   <= '0;
      head       <= NULL;
      free_head  <= NULL;
      free_next  <= NULL;
      count      <= '0;
      n_ptr      <= NULL;
      cur        <= NULL;
      prev       <= NULL;
      new_tag    <= '0;
      prev_tag   <= '0;
      first_walk <= 1'b0;
      out_valid  <= 1'b0;
      out_tag    <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == LAST_IDX) begin
            free_head <= N'(1);
            head      <= NULL;
            count     <= '0;
          end
        end
        S_IDLE: begin
          if (ins_go) begin
            new_tag    <= in_tag;
            n_ptr      <= free_head;
            cur        <= head;
            prev       <= NULL;
            prev_tag   <= '0;
            first_walk <= 1'b1;
          end
        end
        S_WALK: begin
          first_walk <= 1'b0;
          // r_data2 holds the free head block only in the first WALK cycle.
          if (first_walk) free_next <= rd2_next;
          if (walk_adv) begin
            prev     <= cur;
            prev_tag <= rd1_tag;
            cur      <= rd1_next;
          end
        end
        S_LINK1: ;
        S_LINK2: begin
          if (prev == NULL) head <= n_ptr;
          free_head <= free_next;
          count     <= count + 1'b1;
        end
        S_POP_RD: begin
          free_head <= head;
          head      <= rd1_next;
          count     <= count - 1'b1;
          out_tag   <= rd1_tag;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tagsort_list_ctrl.md
TAGSORT_LIST_CTRL -- requirements
Module: tagsort_list_ctrl

Interface
REQ-001 SHALL have parameter N, default 13, memory address width in bits.
REQ-002 SHALL have parameter B, default 64, memory block width in bits.
REQ-003 SHALL have parameter TW, default 16, tag width; N+TW <= B.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_tag (input, TW) forming the insert handshake.
REQ-007 SHALL have ports pop_req (input, 1), pop_ready (output, 1), out_valid (output, 1) and out_tag (output, TW) for pop-minimum.
REQ-008 SHALL have ports count (output, N) for the number of stored tags, and busy (output, 1) high while not in IDLE.
REQ-009 SHALL have memory-side ports r_addr1 (output, N), r_addr2 (output, N), r_data1 (input, B), r_data2 (input, B), wr_en (output, 1), w_addr (output, N) and w_data (output, B); memory read latency is 1 cycle, registered, read-first.

Function
REQ-010 SHALL hold tags in an ascending, stable-sorted singly linked list; block layout: next = [N-1:0], tag = [N+TW-1:N], all other bits 0; pointer 0 = NULL, capacity 2^N-1.
REQ-011 SHALL keep registers head (sorted list), free_head (free list) and count.
REQ-012 SHALL implement states INIT, IDLE, WALK, LINK1, LINK2, POP_RD.
REQ-013 SHALL in INIT write RAM[i] = {0, (i+1) mod 2^N} for i = 0..2^N-1, one entry per cycle; then set free_head=1, head=NULL, count=0 and enter IDLE.
REQ-014 SHALL in IDLE drive r_addr1=head and r_addr2=free_head; in_ready = (count < 2^N-1) and no pop accepted this cycle; pop_ready = (count != 0).
REQ-015 SHALL accept a pop when pop_req and pop_ready are high in IDLE; a pop has priority over a simultaneous insert, and in_ready SHALL be low in that cycle.
REQ-016 SHALL accept an insert when in_valid and in_ready are high; on acceptance, latch in_tag, n=free_head, cur=head, prev=NULL, and enter WALK.
REQ-017 SHALL on the first WALK cycle capture free_next = next(r_data2).
REQ-018 SHALL in WALK, while cur != NULL and tag(r_data1) <= new tag, set prev=cur, cur=next(r_data1), drive r_addr1=next(r_data1) combinationally and stay in WALK; otherwise enter LINK1.
REQ-019 SHALL in LINK1 write RAM[n] = {new tag, cur}.
REQ-020 SHALL in LINK2 write RAM[prev] = {tag(prev), n} if prev != NULL, else set head=n; also set free_head=free_next, increment count and return to IDLE.
REQ-021 SHALL give insert latency: accept at cycle T, IDLE again at T+k+4, where k = number of existing nodes with tag <= new tag.
REQ-022 SHALL on pop acceptance at T: in POP_RD (T+1) write RAM[head] = {0, free_head}, set free_head=head, head=next(r_data1), decrement count, and register out_tag=tag(r_data1); then pulse out_valid for exactly one cycle at T+2 and return to IDLE.
REQ-023 SHALL hold wr_en low in every state except INIT, LINK1, LINK2 (prev != NULL) and POP_RD.
REQ-024 SHALL never accept an insert when count = 2^N-1 or a pop when count = 0; the pointers SHALL remain unchanged in both cases.
REQ-025 SHALL place equal tags after existing equal tags (FIFO order among ties).

Reset
REQ-026 SHALL on rst force state=INIT with init index 0, and outputs in_ready=0, pop_ready=0, out_valid=0, out_tag=0, count=0, busy=1, wr_en=0, and all addresses and w_data at 0.
REQ-027 SHALL, on reset mid-operation, abandon the operation and rebuild the free list through INIT; no prior contents SHALL survive.

Structure
REQ-028 SHALL take NULL_PTR, the next/tag field offsets and the state encoding from shared package tagsort_pkg.
REQ-029 SHALL contain no sub-module; the dual-port memory is instantiated beside it in the parent tagsort_top.

Verification (N=3, TW=8, capacity 7)
REQ-030 SHALL verify reset: after rst release, busy=1 for 8 cycles with w_addr 0..7 and w_data next 1..7,0, then in_ready=1 and count=0.
REQ-031 SHALL verify sorted insert: inserting 5, 2, 9, 2 then popping four times yields out_tag 2, 2, 5, 9, and insert 9 returns to IDLE 2+4 cycles after acceptance.
REQ-032 SHALL verify full: after 7 inserts, count=7 and in_ready=0; an 8th in_valid held is not accepted until one pop completes.
REQ-033 SHALL verify empty: a pop_req with count=0 gives pop_ready=0, no out_valid and no write.
REQ-034 SHALL verify simultaneous events: in_valid and pop_req together with count=3 serve the pop first (out_valid at T+2), then accept the insert.
REQ-035 SHALL verify recycling: 20 alternating insert/pop pairs keep count within 0..1 and return free_head to a valid chain of 7 entries.
